sar_ctrl: RTL and testbench

- Successive-approximation controller directly downstream of the comparator post-processor.
- Consumes its comp/valid decision pair, drives the comparator enable, and steps the capacitive-DAC trial code MSB-first.
- Presents the final N-bit conversion result with a one-cycle done strobe.
- Handles comparator no-decision (metastable) events with a per-bit timeout.

---
 rtl/sar_pkg.sv | 15 +
 rtl/sar_ctrl_if.sv | 27 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/sar_ctrl.sv | 158 +++++++++++++++
 tb/tb_sar_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/sar_pkg.sv
`timescale 1ns/1ps
// Shared types and defaults for the SAR ADC controller.
package sar_pkg;
  localparam int N_BITS_DEF         = 8;
  localparam int SAMPLE_CYCLES_DEF  = 2;
  localparam int TIMEOUT_CYCLES_DEF = 16;
  localparam int MAX_BITS           = 32;

  typedef enum logic [2:0] {IDLE, SAMPLE, COMPARE, SETTLE, DONE} sar_state_t;

  // First trial code of a conversion: only the MSB set.
  function automatic logic [MAX_BITS-1:0] midscale(input int unsigned n);
    return MAX_BITS'(1) << (n - 1);
  endfunction
endpackage

// File: rtl/sar_ctrl_if.sv
`timescale 1ns/1ps
// Controller <-> comparator/DAC/host signal bundle.
interface sar_ctrl_if
  import sar_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
) ();
  logic              start;
  logic              comp;
  logic              valid;
  logic              sample;
  logic              cmp_en;
  logic [N_BITS-1:0] dac_code;
  logic [N_BITS-1:0] dout;
  logic              done;
  logic              busy;
  logic              meta_flag;

  modport master (
    input  start, comp, valid,
    output sample, cmp_en, dac_code, dout, done, busy, meta_flag
  );
  modport slave (
    output start, comp, valid,
    input  sample, cmp_en, dac_code, dout, done, busy, meta_flag
  );
endinterface

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
// Generic two-flop synchronizer with asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_s1, r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;
endmodule

// File: rtl/sar_ctrl.sv
`timescale 1ns/1ps
// Successive-approximation controller: sample, MSB-first bit trials with
// per-bit comparator timeout, and a registered result with a done strobe.
module sar_ctrl
  import sar_pkg::*;
#(
  parameter int N_BITS         = N_BITS_DEF,
  parameter int SAMPLE_CYCLES  = SAMPLE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  sar_ctrl_if.master bus
);
  localparam int IW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int SW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  sar_state_t        r_state, w_state_nxt;
  logic              r_sample, w_sample_nxt;
  logic              r_cmp_en, w_cmp_en_nxt;
  logic [N_BITS-1:0] r_dac, w_dac_nxt;
  logic [N_BITS-1:0] r_dout, w_dout_nxt;
  logic              r_done, w_done_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_meta, w_meta_nxt;
  logic              r_meta_st, w_meta_st_nxt;
  logic [IW-1:0]     r_bit, w_bit_nxt;
  logic [TW-1:0]     r_tcnt, w_tcnt_nxt;
  logic [SW-1:0]     r_scnt, w_scnt_nxt;
  logic              w_valid_s;
  logic              w_dec, w_d;

  sync_2ff u_valid_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.valid),
    .o_q   (w_valid_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sample  <= 1'b0;
      r_cmp_en  <= 1'b0;
      r_dac     <= '0;
      r_dout    <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_meta    <= 1'b0;
      r_meta_st <= 1'b0;
      r_bit     <= '0;
      r_tcnt    <= '0;
      r_scnt    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sample  <= w_sample_nxt;
      r_cmp_en  <= w_cmp_en_nxt;
      r_dac     <= w_dac_nxt;
      r_dout    <= w_dout_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= w_busy_nxt;
      r_meta    <= w_meta_nxt;
      r_meta_st <= w_meta_st_nxt;
      r_bit     <= w_bit_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_scnt    <= w_scnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sample_nxt  = r_sample;
    w_cmp_en_nxt  = r_cmp_en;
    w_dac_nxt     = r_dac;
    w_dout_nxt    = r_dout;
    w_done_nxt    = 1'b0;
    w_busy_nxt    = r_busy;
    w_meta_nxt    = r_meta;
    w_meta_st_nxt = r_meta_st;
    w_bit_nxt     = r_bit;
    w_tcnt_nxt    = r_tcnt;
    w_scnt_nxt    = r_scnt;
    w_dec         = 1'b0;
    w_d           = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt   = SAMPLE;
          w_sample_nxt  = 1'b1;
          w_busy_nxt    = 1'b1;
          w_dac_nxt     = N_BITS'(midscale(N_BITS));
          w_bit_nxt     = IW'(N_BITS - 1);
          w_meta_st_nxt = 1'b0;
          w_scnt_nxt    = '0;
        end
      end
      SAMPLE: begin
        if (r_scnt == SW'(SAMPLE_CYCLES - 1)) begin
          w_state_nxt  = COMPARE;
          w_sample_nxt = 1'b0;
          w_cmp_en_nxt = 1'b1;
          w_tcnt_nxt   = '0;
        end else begin
          w_scnt_nxt = r_scnt + 1'b1;
        end
      end
      COMPARE: begin
        // A real decision outranks a timeout landing in the same cycle.
        if (w_valid_s) begin
          w_dec = 1'b1;
          w_d   = bus.comp;
        end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          w_dec         = 1'b1;
          w_d           = 1'b1;
          w_meta_st_nxt = 1'b1;
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
        if (w_dec) begin
          w_dac_nxt[r_bit] = w_d;
          if (r_bit != '0) w_dac_nxt[IW'(r_bit - 1'b1)] = 1'b1;
          w_cmp_en_nxt = 1'b0;
          w_state_nxt  = SETTLE;
        end
      end
      SETTLE: begin
        // Hold off until the previous decision has drained from the synchronizer.
        if (!w_valid_s) begin
          if (r_bit == '0) begin
            w_state_nxt = DONE;
            w_dout_nxt  = r_dac;
            w_meta_nxt  = r_meta_st;
            w_done_nxt  = 1'b1;
          end else begin
            w_bit_nxt    = r_bit - 1'b1;
            w_tcnt_nxt   = '0;
            w_cmp_en_nxt = 1'b1;
            w_state_nxt  = COMPARE;
          end
        end
      end
      DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.sample    = r_sample;
  assign bus.cmp_en    = r_cmp_en;
  assign bus.dac_code  = r_dac;
  assign bus.dout      = r_dout;
  assign bus.done      = r_done;
  assign bus.busy      = r_busy;
  assign bus.meta_flag = r_meta;
endmodule

// File: tb/tb_sar_ctrl.sv
`timescale 1ns/1ps
// Directed bench for sar_ctrl with an ideal comparator model driven per cycle.
module tb_sar_ctrl;
  import sar_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sar_ctrl_if #(.N_BITS(8)) bus ();

  sar_ctrl #(.N_BITS(8), .SAMPLE_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int busy_cnt, done_cnt, rises, vhold, t0, lat, d1, d2;
  int mute_bit = -1;
  int stuck_bit = -1;
  int stuck_len = 1;
  int rise_cyc [8];
  logic prev_en = 1'b0;
  logic [7:0] vin = 8'h00;
  logic ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample DUT just after the edge, then update the comparator model.
  // The comparator emits a one-cycle valid in the first cycle cmp_en is high.
  task automatic tick();
    int b;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.busy) busy_cnt++;
    if (bus.done) done_cnt++;
    if (bus.sample) rises = 0;
    if (bus.cmp_en && !prev_en) begin
      b = 7 - rises;
      rises++;
      if (b >= 0 && b <= 7) rise_cyc[b] = cyc;
      vhold = (b == mute_bit) ? 0 : (b == stuck_bit) ? stuck_len : 1;
    end
    prev_en = bus.cmp_en;
    bus.valid = (vhold > 0);
    if (vhold > 0) vhold--;
    bus.comp = (vin >= bus.dac_code);
  endtask

  task automatic wait_done(output logic found);
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (bus.done) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // lat = cycle number of the done pulse, counting the start cycle as 1.
  task automatic run_conv(input logic [7:0] v, output int l);
    logic f;
    vin = v;
    busy_cnt = 0;
    done_cnt = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    t0 = cyc;
    wait_done(f);
    check("done_seen", f, 1);
    l = cyc - t0 + 2;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sample"}, bus.sample, 0);
    check({tag, "_cmp_en"}, bus.cmp_en, 0);
    check({tag, "_dac"}, bus.dac_code, 0);
    check({tag, "_dout"}, bus.dout, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_meta"}, bus.meta_flag, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.valid = 1'b0;
    bus.comp  = 1'b0;
    busy_cnt = 0; done_cnt = 0; rises = 0; vhold = 0;
    #12;
    check_zero("rst");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    run_conv(8'hA5, lat);
    check("a5_dout", bus.dout, 8'hA5);
    check("a5_meta", bus.meta_flag, 0);
    check("a5_lat", lat, 36);
    check("a5_busy_cycles", busy_cnt, 35);
    tick();
    check("a5_done_low", bus.done, 0);
    check("a5_busy_low", bus.busy, 0);
    check("a5_dac_hold", bus.dac_code, 8'hA5);

    run_conv(8'h00, lat);
    check("z_dout", bus.dout, 8'h00);
    tick();
    run_conv(8'hFF, lat);
    check("ff_dout", bus.dout, 8'hFF);
    tick();
    run_conv(8'h80, lat);
    check("80_dout", bus.dout, 8'h80);
    tick();

    mute_bit = 5;
    run_conv(8'h00, lat);
    mute_bit = -1;
    check("to_dout", bus.dout, 8'h20);
    check("to_meta", bus.meta_flag, 1);
    check("to_lat", lat, 49);
    check("to_bit5_cycles", rise_cyc[4] - rise_cyc[5], 17);
    check("to_bit7_cycles", rise_cyc[6] - rise_cyc[7], 4);
    tick();

    // start re-asserted mid-conversion must be ignored
    vin = 8'h33;
    done_cnt = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 60; k++) begin
      bus.start = (cyc - t0 == 8);
      tick();
    end
    bus.start = 1'b0;
    check("ign_done_cnt", done_cnt, 1);
    check("ign_dout", bus.dout, 8'h33);
    check("ign_busy", bus.busy, 0);

    // start held: back-to-back conversions, one IDLE cycle between
    vin = 8'h77;
    bus.start = 1'b1;
    wait_done(ok);
    check("b2b_done1", ok, 1);
    d1 = cyc;
    check("b2b_dout1", bus.dout, 8'h77);
    wait_done(ok);
    d2 = cyc;
    bus.start = 1'b0;
    check("b2b_done2", ok, 1);
    check("b2b_period", d2 - d1, 36);
    check("b2b_dout2", bus.dout, 8'h77);
    tick(); tick();

    // reset asserted during bit-3 compare
    vin = 8'h55;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (rises == 5 && bus.cmp_en) begin
        ok = 1'b1;
        break;
      end
    end
    check("mid_reached_bit3", ok, 1);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    tick(); tick();
    rst_n = 1'b1;
    vhold = 0;
    bus.valid = 1'b0;
    tick();
    run_conv(8'h3C, lat);
    check("post_rst_dout", bus.dout, 8'h3C);
    check("post_rst_meta", bus.meta_flag, 0);
    check("post_rst_lat", lat, 36);
    tick();

    // valid held high past the decision: SETTLE must wait for valid_s to drop
    stuck_bit = 4;
    stuck_len = 5;
    run_conv(8'h5A, lat);
    stuck_bit = -1;
    check("stuck_dout", bus.dout, 8'h5A);
    check("stuck_meta", bus.meta_flag, 0);
    check("stuck_bit4_cycles", rise_cyc[3] - rise_cyc[4], 8);
    check("stuck_lat", lat, 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
